rob_commit: RTL and testbench
=============================

# rob_commit

In-order retirement unit for the out-of-order RV32I core; consumes the ROB head entry and is the single reader/dequeuer of the ROB. It decides when the head may retire and pulses the ROB dequeue. It writes the architectural register file, sequences committed stores with the store path, and raises the pipeline-wide flush on a taken branch. The flush drives `cdbus.flush`.

## Interface
- `ROB_IDX_W`, 5: ROB index width (32 entries).
- `FLUSH_CYCLES`, 1: cycles `flush_o` is held (1..15).
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `head_i` in `rob_entry_t`: ROB entry at head, combinational from ROB.
- `head_idx_i` in ROB_IDX_W: ROB head pointer.
- `dequeue_o` out 1: combinational; retire head this cycle.
- `regf_we_o` out 1: registered architectural write enable.
- `regf_rd_addr_o` out 5: registered write register address.
- `regf_rd_data_o` out 32: registered write data.
- `regf_rob_idx_o` out ROB_IDX_W: registered ROB index of the retired entry; the RAT clears its mapping if it still matches.
- `store_commit_o` out 1: store request to the memory path.
- `store_addr_o` out 32: store address.
- `store_wdata_o` out 32: store data.
- `store_wmask_o` out 4: store byte mask.
- `store_ack_i` in 1: store accepted.
- `flush_o` out 1: registered pipeline flush.
- `pc_redirect_o` out 32: registered redirect PC, valid with `flush_o`.
- `retire_valid_o` out 1: registered; one instruction retired.

## Operation
- States: READY, STORE_WAIT, FLUSH.
- Head is retireable when `head_i.valid && head_i.status == done`.

**READY**
- Head retireable and `mem_wmask == 0`: `dequeue_o=1` this cycle.
  - Next edge: `retire_valid_o=1`.
  - Next edge: `regf_we_o = regf_we && rd_addr != 0`.
  - Next edge: `regf_rd_addr_o`/`regf_rd_data_o`/`regf_rob_idx_o` take head `rd_addr`/`rd_data`/`head_idx_i`.
  - If `br_en==1` (taken = mispredict, fetch predicts not-taken): enter FLUSH; `flush_o=1` and `pc_redirect_o=pc_new` from next edge.
  - Otherwise stay in READY; back-to-back retirement at 1/cycle.
- Head retireable and `mem_wmask != 0` (store): `dequeue_o=0`; enter STORE_WAIT; latch `mem_addr`/`mem_wdata`/`mem_wmask` into `store_*_o`.
- Head not retireable, or `valid=0`: no action.

**STORE_WAIT**
- `store_commit_o=1`; store fields held stable.
- On `store_ack_i`: `dequeue_o=1` same cycle; `store_commit_o` deasserts next edge; `retire_valid_o` pulses; no regfile write; return to READY.
- Without ack: wait indefinitely.

**FLUSH**
- `flush_o` held FLUSH_CYCLES cycles by a down-counter; `dequeue_o=0` throughout.
- Then return to READY with `flush_o=0`.
- The ROB empties itself on flush; the first head seen afterwards is post-flush.

**General**
- `retire_valid_o`, `regf_we_o` are single-cycle pulses.
- `dequeue_o` is never asserted in FLUSH and never asserted twice for one entry.

## Timing
- Reset values:
  - State READY.
  - `regf_we_o=0`, `regf_rd_addr_o=0`, `regf_rd_data_o=0`, `regf_rob_idx_o=0`.
  - `store_commit_o=0`, `store_addr_o=0`, `store_wdata_o=0`, `store_wmask_o=0`.
  - `flush_o=0`, `pc_redirect_o=0`, `retire_valid_o=0`.
  - Order counter 0.
- Non-store retire: `dequeue_o` in cycle t; regfile outputs and `retire_valid_o` at t+1.
- Store: enters STORE_WAIT at t+1; earliest `dequeue_o` at t+1 if `store_ack_i` is already high.
- Mispredict: `flush_o` high t+1 .. t+FLUSH_CYCLES; earliest next `dequeue_o` at t+FLUSH_CYCLES+1.
- `rst` mid-STORE_WAIT or mid-FLUSH: all outputs return to reset values at the next edge; no retire that cycle.
- `store_ack_i` outside STORE_WAIT is ignored.

## Configuration
- `ROB_COMMIT_RVFI_EN` defined:
  - Adds a 64-bit retire order counter, incremented on each retirement.
  - Adds registered monitor outputs aligned with `retire_valid_o`:
    - `rvfi_order_o` (pre-increment value).
    - `rvfi_insn_o`, `rvfi_pc_rdata_o`.
    - `rvfi_pc_wdata_o` (`pc_new` if `br_en`, else `pc+4`).
    - `rvfi_rs1_addr_o`, `rvfi_rs2_addr_o`.
    - `rvfi_rd_addr_o`, `rvfi_rd_wdata_o` (0 when rd=x0).
    - `rvfi_mem_*_o` copied from the entry.
- Undefined: counter and `rvfi_*` ports are absent; all other behaviour is identical.

## Test plan
- Reset, then done head with `rd=5`, `rd_data=0xDEADBEEF`, `regf_we=1`, idx 3 → `dequeue_o=1` same cycle; next cycle `regf_we_o=1`, addr 5, data `0xDEADBEEF`, rob_idx 3.
- Three consecutive done non-store heads → `dequeue_o` high three consecutive cycles; order 0,1,2 (RVFI build).
- Done head with `rd=0`, `regf_we=1` → retires with `regf_we_o=0`.
- Store head, `addr=0x1000`, `wmask=0xF`, `wdata=0x12345678`; ack held off 4 cycles → `store_commit_o` high 4 cycles with stable fields; `dequeue_o` only in the ack cycle; `regf_we_o` stays 0.
- Branch head, `br_en=1`, `pc_new=0x60000040`, FLUSH_CYCLES=2 → `flush_o` high 2 cycles with `pc_redirect_o=0x60000040`; a done head presented during FLUSH is not dequeued.
- `rst` asserted in STORE_WAIT → next cycle `store_commit_o=0`, state READY, no `dequeue_o`.

Source files
------------

// File: rtl/rob_commit_if.sv
// rob_commit_if: ROB-head / regfile / store-path / flush bundle around the commit unit.
//   master: commit unit (consumes head, head_idx, store_ack; drives the rest)
//   slave : surrounding pipeline (ROB, RAT/regfile, store path, fetch)
//   ROB_COMMIT_RVFI_EN adds the rvfi_* monitor signals.
interface rob_commit_if #(parameter int ROB_IDX_W = 5);
   typedef struct packed {
      logic        valid;
      logic [1:0]  status;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      logic        regf_we;
      logic        br_en;
      logic [31:0] pc_new;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [31:0] mem_rdata;
      logic [3:0]  mem_wmask;
      logic [3:0]  mem_rmask;
   } rob_entry_t;
   rob_entry_t           head;
   logic [ROB_IDX_W-1:0] head_idx;
   logic                 dequeue;
   logic                 regf_we;
   logic [4:0]           regf_rd_addr;
   logic [31:0]          regf_rd_data;
   logic [ROB_IDX_W-1:0] regf_rob_idx;
   logic                 store_commit;
   logic [31:0]          store_addr;
   logic [31:0]          store_wdata;
   logic [3:0]           store_wmask;
   logic                 store_ack;
   logic                 flush;
   logic [31:0]          pc_redirect;
   logic                 retire_valid;
`ifdef ROB_COMMIT_RVFI_EN
   logic [63:0]          rvfi_order;
   logic [31:0]          rvfi_insn;
   logic [31:0]          rvfi_pc_rdata;
   logic [31:0]          rvfi_pc_wdata;
   logic [4:0]           rvfi_rs1_addr;
   logic [4:0]           rvfi_rs2_addr;
   logic [4:0]           rvfi_rd_addr;
   logic [31:0]          rvfi_rd_wdata;
   logic [31:0]          rvfi_mem_addr;
   logic [31:0]          rvfi_mem_wdata;
   logic [31:0]          rvfi_mem_rdata;
   logic [3:0]           rvfi_mem_wmask;
   logic [3:0]           rvfi_mem_rmask;
`endif
   modport master (
      input  head, head_idx, store_ack,
      output dequeue, regf_we, regf_rd_addr, regf_rd_data, regf_rob_idx,
             store_commit, store_addr, store_wdata, store_wmask,
             flush, pc_redirect, retire_valid
`ifdef ROB_COMMIT_RVFI_EN
      , output rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rd_wdata,
             rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata, rvfi_mem_wmask, rvfi_mem_rmask
`endif
   );
   modport slave (
      output head, head_idx, store_ack,
      input  dequeue, regf_we, regf_rd_addr, regf_rd_data, regf_rob_idx,
             store_commit, store_addr, store_wdata, store_wmask,
             flush, pc_redirect, retire_valid
`ifdef ROB_COMMIT_RVFI_EN
      , input rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rd_wdata,
             rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata, rvfi_mem_wmask, rvfi_mem_rmask
`endif
   );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement of the ROB head (regfile write, store sequencing, branch flush).
//   clk, rst : clock, synchronous active-high reset
//   bus      : rob_commit_if.master (head entry in; dequeue, regfile, store, flush, retire out)
//   ROB_COMMIT_RVFI_EN : adds the 64-bit retire order counter and rvfi_* monitor outputs.
module rob_commit #(
   parameter int ROB_IDX_W    = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input logic         clk,
   input logic         rst,
   rob_commit_if.master bus
);
   localparam logic [1:0] ST_DONE = 2'd2;
   typedef enum logic [1:0] {READY, STORE_WAIT, FLUSH} state_t;
   state_t     state;
   logic [3:0] flush_cnt;
   logic       retireable;
   logic       is_store;
   always_comb begin
      retireable  = bus.head.valid && bus.head.status == ST_DONE;
      is_store    = bus.head.mem_wmask != 4'd0;
      // Gated by rst so an entry is never popped in a cycle whose retire gets wiped.
      bus.dequeue = !rst && (state == READY ? retireable && !is_store
                                            : state == STORE_WAIT && bus.store_ack);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= READY;
         flush_cnt        <= 4'd0;
         bus.regf_we      <= 1'b0;
         bus.regf_rd_addr <= 5'd0;
         bus.regf_rd_data <= 32'd0;
         bus.regf_rob_idx <= {ROB_IDX_W{1'b0}};
         bus.store_commit <= 1'b0;
         bus.store_addr   <= 32'd0;
         bus.store_wdata  <= 32'd0;
         bus.store_wmask  <= 4'd0;
         bus.flush        <= 1'b0;
         bus.pc_redirect  <= 32'd0;
         bus.retire_valid <= 1'b0;
      end else begin
         bus.retire_valid <= bus.dequeue;
         bus.regf_we      <= 1'b0;
         case (state)
            READY: if (retireable) begin
               if (!is_store) begin
                  bus.regf_we      <= bus.head.regf_we && bus.head.rd_addr != 5'd0;
                  bus.regf_rd_addr <= bus.head.rd_addr;
                  bus.regf_rd_data <= bus.head.rd_data;
                  bus.regf_rob_idx <= bus.head_idx;
                  // Fetch predicts not-taken, so any taken branch is a mispredict.
                  if (bus.head.br_en) begin
                     state           <= FLUSH;
                     bus.flush       <= 1'b1;
                     bus.pc_redirect <= bus.head.pc_new;
                     flush_cnt       <= 4'(FLUSH_CYCLES - 1);
                  end
               end else begin
                  state            <= STORE_WAIT;
                  bus.store_commit <= 1'b1;
                  bus.store_addr   <= bus.head.mem_addr;
                  bus.store_wdata  <= bus.head.mem_wdata;
                  bus.store_wmask  <= bus.head.mem_wmask;
               end
            end
            STORE_WAIT: if (bus.store_ack) begin
               state            <= READY;
               bus.store_commit <= 1'b0;
            end
            FLUSH: if (flush_cnt == 4'd0) begin
               state     <= READY;
               bus.flush <= 1'b0;
            end else flush_cnt <= flush_cnt - 4'd1;
            default: state <= READY;
         endcase
      end
   end
`ifdef ROB_COMMIT_RVFI_EN
   logic [63:0] order;
   always_ff @(posedge clk) begin
      if (rst) begin
         order              <= 64'd0;
         bus.rvfi_order     <= 64'd0;
         bus.rvfi_insn      <= 32'd0;
         bus.rvfi_pc_rdata  <= 32'd0;
         bus.rvfi_pc_wdata  <= 32'd0;
         bus.rvfi_rs1_addr  <= 5'd0;
         bus.rvfi_rs2_addr  <= 5'd0;
         bus.rvfi_rd_addr   <= 5'd0;
         bus.rvfi_rd_wdata  <= 32'd0;
         bus.rvfi_mem_addr  <= 32'd0;
         bus.rvfi_mem_wdata <= 32'd0;
         bus.rvfi_mem_rdata <= 32'd0;
         bus.rvfi_mem_wmask <= 4'd0;
         bus.rvfi_mem_rmask <= 4'd0;
      end else if (bus.dequeue) begin
         order              <= order + 64'd1;
         bus.rvfi_order     <= order;
         bus.rvfi_insn      <= bus.head.insn;
         bus.rvfi_pc_rdata  <= bus.head.pc;
         bus.rvfi_pc_wdata  <= bus.head.br_en ? bus.head.pc_new : bus.head.pc + 32'd4;
         bus.rvfi_rs1_addr  <= bus.head.rs1_addr;
         bus.rvfi_rs2_addr  <= bus.head.rs2_addr;
         bus.rvfi_rd_addr   <= bus.head.rd_addr;
         bus.rvfi_rd_wdata  <= bus.head.rd_addr == 5'd0 ? 32'd0 : bus.head.rd_data;
         bus.rvfi_mem_addr  <= bus.head.mem_addr;
         bus.rvfi_mem_wdata <= bus.head.mem_wdata;
         bus.rvfi_mem_rdata <= bus.head.mem_rdata;
         bus.rvfi_mem_wmask <= bus.head.mem_wmask;
         bus.rvfi_mem_rmask <= bus.head.mem_rmask;
      end
   end
`endif
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed plus randomized checking of rob_commit against a cycle-numbered retirement model.
module tb_rob_commit;
   localparam int IW = 5;
   localparam int FC = 2;
   localparam logic [1:0] DONE = 2'd2;
   typedef struct {
      bit          valid;
      logic [1:0]  status;
      logic [31:0] pc, insn, rd_data, pc_new, mem_addr, mem_wdata, mem_rdata;
      logic [4:0]  rs1, rs2, rd;
      bit          regf_we, br_en;
      logic [3:0]  mem_wmask, mem_rmask;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   rob_commit_if #(.ROB_IDX_W(IW)) bus();
   rob_commit #(.ROB_IDX_W(IW), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   // model of the architecturally visible retirement outcome
   int          cyc = 0;
   int          flush_end = -1;
   bit          st_wait = 0;
   bit          e_rv = 0, e_we = 0;
   logic [4:0]  e_rd = '0, e_idx = '0, hidx = '0;
   logic [31:0] e_rdd = '0, e_pcr = '0, e_saddr = '0, e_swdata = '0;
   logic [3:0]  e_smask = '0;
   logic [63:0] order = '0, e_order = '0;
   logic [31:0] e_pcw = '0, e_rdw = '0;
   ent_t        cur;
   bit          ack_in = 0;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic ent_t gen();
      ent_t e;
      e.valid     = 1;
      e.status    = DONE;
      e.pc        = $urandom & 32'hFFFF_FFFC;
      e.insn      = $urandom;
      e.rs1       = 5'($urandom);
      e.rs2       = 5'($urandom);
      e.rd        = 5'($urandom);
      e.rd_data   = $urandom;
      e.regf_we   = 1'($urandom);
      e.mem_addr  = $urandom;
      e.mem_wdata = $urandom;
      e.mem_rdata = $urandom;
      e.mem_rmask = 4'($urandom);
      e.mem_wmask = ($urandom_range(9) < 3) ? 4'($urandom_range(15, 1)) : 4'd0;
      e.br_en     = e.mem_wmask == 4'd0 && $urandom_range(9) < 2;
      e.pc_new    = $urandom & 32'hFFFF_FFFC;
      return e;
   endfunction
   // Called at posedge+1: drives cur/ack_in/rst, checks mid-cycle, then advances the model past the edge.
   task automatic cycle(output bit deq);
      bit fl, rt;
      bus.head.valid     = cur.valid;
      bus.head.status    = cur.status;
      bus.head.pc        = cur.pc;
      bus.head.insn      = cur.insn;
      bus.head.rs1_addr  = cur.rs1;
      bus.head.rs2_addr  = cur.rs2;
      bus.head.rd_addr   = cur.rd;
      bus.head.rd_data   = cur.rd_data;
      bus.head.regf_we   = cur.regf_we;
      bus.head.br_en     = cur.br_en;
      bus.head.pc_new    = cur.pc_new;
      bus.head.mem_addr  = cur.mem_addr;
      bus.head.mem_wdata = cur.mem_wdata;
      bus.head.mem_rdata = cur.mem_rdata;
      bus.head.mem_wmask = cur.mem_wmask;
      bus.head.mem_rmask = cur.mem_rmask;
      bus.head_idx       = hidx;
      bus.store_ack      = ack_in;
      #2;
      fl  = cyc <= flush_end;
      rt  = cur.valid && cur.status == DONE;
      deq = !rst && !fl && (st_wait ? ack_in : rt && cur.mem_wmask == 4'd0);
      check("dequeue", bus.dequeue, deq);
      check("retire_valid", bus.retire_valid, e_rv);
      check("regf_we", bus.regf_we, e_we);
      check("regf_rd_addr", bus.regf_rd_addr, e_rd);
      check("regf_rd_data", bus.regf_rd_data, e_rdd);
      check("regf_rob_idx", bus.regf_rob_idx, e_idx);
      check("store_commit", bus.store_commit, st_wait);
      check("store_addr", bus.store_addr, e_saddr);
      check("store_wdata", bus.store_wdata, e_swdata);
      check("store_wmask", bus.store_wmask, e_smask);
      check("flush", bus.flush, fl);
      check("pc_redirect", bus.pc_redirect, e_pcr);
`ifdef ROB_COMMIT_RVFI_EN
      if (e_rv) begin
         check("rvfi_order", bus.rvfi_order, e_order);
         check("rvfi_pc_wdata", bus.rvfi_pc_wdata, e_pcw);
         check("rvfi_rd_wdata", bus.rvfi_rd_wdata, e_rdw);
      end
`endif
      @(posedge clk);
      #1;
      if (rst) begin
         st_wait = 0; flush_end = -1; e_rv = 0; e_we = 0;
         e_rd = '0; e_rdd = '0; e_idx = '0; e_pcr = '0;
         e_saddr = '0; e_swdata = '0; e_smask = '0; order = '0;
      end else begin
         e_rv = deq;
         e_we = 0;
         if (!fl && !st_wait && rt) begin
            if (cur.mem_wmask == 4'd0) begin
               e_we  = cur.regf_we && cur.rd != 5'd0;
               e_rd  = cur.rd;
               e_rdd = cur.rd_data;
               e_idx = hidx;
               if (cur.br_en) begin
                  flush_end = cyc + FC;
                  e_pcr     = cur.pc_new;
               end
            end else begin
               st_wait  = 1;
               e_saddr  = cur.mem_addr;
               e_swdata = cur.mem_wdata;
               e_smask  = cur.mem_wmask;
            end
         end else if (st_wait && ack_in) st_wait = 0;
         if (deq) begin
            e_order = order;
            order++;
            e_pcw   = cur.br_en ? cur.pc_new : cur.pc + 32'd4;
            e_rdw   = cur.rd == 5'd0 ? 32'd0 : cur.rd_data;
            hidx++;
         end
      end
      cyc++;
   endtask
   initial begin
      bit d;
      cur = gen();
      cur.valid = 0;
      bus.head = '0;
      bus.head_idx = '0;
      bus.store_ack = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      cycle(d);
      // single retire with regfile write
      cur = gen();
      cur.rd = 5; cur.rd_data = 32'hDEADBEEF; cur.regf_we = 1; cur.mem_wmask = 0; cur.br_en = 0;
      hidx = 5'd3;
      cycle(d);
      cur.valid = 0;
      cycle(d);
      // three back-to-back plain retires
      for (int i = 0; i < 3; i++) begin
         cur = gen(); cur.mem_wmask = 0; cur.br_en = 0;
         cycle(d);
      end
      // rd = x0 never writes
      cur = gen(); cur.rd = 0; cur.regf_we = 1; cur.mem_wmask = 0; cur.br_en = 0;
      cycle(d);
      // store with ack held off for 4 commit cycles
      cur = gen(); cur.mem_addr = 32'h1000; cur.mem_wmask = 4'hF; cur.mem_wdata = 32'h12345678;
      ack_in = 0;
      for (int i = 0; i < 4; i++) cycle(d);
      ack_in = 1;
      cycle(d);
      ack_in = 0;
      cur.valid = 0;
      cycle(d);
      // mispredicted branch; done heads during flush must wait
      cur = gen(); cur.br_en = 1; cur.mem_wmask = 0; cur.pc_new = 32'h60000040;
      cycle(d);
      cur = gen(); cur.mem_wmask = 0; cur.br_en = 0;
      for (int i = 0; i < FC + 1; i++) cycle(d);
      // reset while waiting for a store ack
      cur = gen(); cur.mem_wmask = 4'h3;
      cycle(d);
      cycle(d);
      rst = 1; ack_in = 1;
      cycle(d);
      rst = 0; ack_in = 0; cur.valid = 0;
      cycle(d);
      // randomized traffic
      cur = gen();
      for (int i = 0; i < 3000; i++) begin
         cur.valid  = $urandom_range(9) != 0;
         cur.status = $urandom_range(9) < 7 ? DONE : 2'd1;
         ack_in     = $urandom_range(9) < 4;
         rst        = $urandom_range(299) == 0;
         cycle(d);
         if (d) cur = gen();
      end
      rst = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
